// File: rtl/alu_pipe_core.sv
// Two-stage pipelined 4-bit ALU (ADD/SUB/AND/XOR) with valid/ready on both sides.
// Define ALU_PIPE_STATS_EN to build the saturating op/carry statistics counters.
module alu_pipe_core #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out,
    output logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] carry_cnt
);

    logic       s1_valid_q, s1_valid_d;
    logic [3:0] s1_a_q, s1_a_d;
    logic [3:0] s1_b_q, s1_b_d;
    logic [1:0] s1_op_q, s1_op_d;
    logic [3:0] out_q, out_d;
    logic       c_q, c_d;
    logic       out_valid_q, out_valid_d;
    logic       s2_advance;
    logic [4:0] alu_res;

    assign s2_advance = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_advance;

    always_comb begin
        alu_res = '0;
        unique case (s1_op_q)
            2'b00: alu_res = {1'b0, s1_a_q} + {1'b0, s1_b_q};
            2'b01: alu_res = {1'b0, s1_a_q} - {1'b0, s1_b_q};
            2'b10: alu_res = {1'b0, s1_a_q & s1_b_q};
            2'b11: alu_res = {1'b0, s1_a_q ^ s1_b_q};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        c_d         = c_q;
        // S1 is either empty or draining into S2 whenever in_ready is high
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = a;
                s1_b_d  = b;
                s1_op_d = op;
            end
        end
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = alu_res[3:0];
                c_d   = alu_res[4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            c_q         <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            c_q         <= c_d;
        end
    end

    assign out       = out_q;
    assign c         = c_q;
    assign out_valid = out_valid_q;

`ifdef ALU_PIPE_STATS_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

    always_comb begin
        op_cnt_d    = op_cnt_q;
        carry_cnt_d = carry_cnt_q;
        if (out_valid_q && out_ready) begin
            if (op_cnt_q != '1) begin
                op_cnt_d = op_cnt_q + CntOne;
            end
            if (c_q && (carry_cnt_q != '1)) begin
                carry_cnt_d = carry_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q    <= '0;
            carry_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign op_cnt    = op_cnt_q;
    assign carry_cnt = carry_cnt_q;
`else
    assign op_cnt    = '0;
    assign carry_cnt = '0;
`endif

endmodule
